// File: rtl/mux_scan_n_to_1.sv
// Registered N-to-1 channel selector with manual select and an auto-scan mode
// that round-robins over enabled channels with a programmable dwell time.
module mux_scan_n_to_1 #(
  parameter int unsigned CH_NUM  = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [CH_NUM*DATA_W-1:0] din,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         dout_ch,
  output logic                     dout_valid,
  output logic                     scan_wrap
);

  localparam int unsigned CH_LAST = CH_NUM - 1;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_STALL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     cur_ch_q, cur_ch_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic [SEL_W-1:0]     dout_ch_q, dout_ch_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 scan_wrap_q, scan_wrap_d;

  logic [SEL_W-1:0]     sel_cl;
  logic [SEL_W-1:0]     low_ch;
  logic [SEL_W-1:0]     up_ch;
  logic                 low_found;
  logic                 up_found;
  logic                 any_en;

  // Clamp manual select; find lowest enabled channel and next one above cur_ch
  always_comb begin
    sel_cl    = (32'(sel) > CH_LAST) ? SEL_W'(CH_LAST) : sel;
    low_ch    = '0;
    up_ch     = '0;
    low_found = 1'b0;
    up_found  = 1'b0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (ch_en[k] && !low_found) begin
        low_ch    = SEL_W'(k);
        low_found = 1'b1;
      end
      if (ch_en[k] && !up_found && (SEL_W'(k) > cur_ch_q)) begin
        up_ch    = SEL_W'(k);
        up_found = 1'b1;
      end
    end
  end

  assign any_en = |ch_en;

  // Next-state and registered-output computation; outputs show the channel
  // the scan will be on after this edge, so each channel is visible dwell+1 cycles
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    dwell_cnt_d  = dwell_cnt_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = 1'b0;
    scan_wrap_d  = 1'b0;
    dout_d       = dout_q;

    if (!mode) begin
      state_d      = ST_MANUAL;
      dout_ch_d    = sel_cl;
      dout_valid_d = 1'b1;
    end else begin
      case (state_q)
        ST_SCAN: begin
          // >= so a shrinking dwell forces an advance instead of a long wrap
          if (dwell_cnt_q >= dwell) begin
            dwell_cnt_d = '0;
            if (up_found) begin
              cur_ch_d = up_ch;
            end else if (any_en) begin
              cur_ch_d    = low_ch;
              scan_wrap_d = 1'b1;
            end else begin
              state_d = ST_STALL;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        default: begin
          if (any_en) begin
            state_d     = ST_SCAN;
            cur_ch_d    = low_ch;
            dwell_cnt_d = '0;
          end else begin
            state_d = ST_STALL;
          end
        end
      endcase
      if (state_d == ST_SCAN) begin
        dout_ch_d    = cur_ch_d;
        dout_valid_d = 1'b1;
      end
    end

    if (dout_valid_d) begin
      dout_d = din[32'(dout_ch_d) * DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_MANUAL;
      cur_ch_q     <= '0;
      dwell_cnt_q  <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      scan_wrap_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      scan_wrap_q  <= scan_wrap_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign scan_wrap  = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// Bench for mux_scan_n_to_1: an 8-channel 1-bit instance checked against a
// cycle-level model, plus a 5-channel 4-bit instance for select clamping.
module tb_mux_scan_n_to_1;

  logic       clk;
  logic       rst_n;

  logic       mode;
  logic [2:0] sel;
  logic [7:0] din8;
  logic [7:0] ch_en;
  logic [7:0] dwell;
  logic [0:0] dout8;
  logic [2:0] dout_ch8;
  logic       valid8;
  logic       wrap8;

  logic        mode5;
  logic [2:0]  sel5;
  logic [19:0] din5;
  logic [4:0]  ch_en5;
  logic [7:0]  dwell5;
  logic [3:0]  dout5;
  logic [2:0]  dout_ch5;
  logic        valid5;
  logic        wrap5;

  mux_scan_n_to_1 #(.CH_NUM(8), .SEL_W(3), .DATA_W(1), .DWELL_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .din(din8),
    .ch_en(ch_en), .dwell(dwell), .dout(dout8), .dout_ch(dout_ch8),
    .dout_valid(valid8), .scan_wrap(wrap8)
  );

  mux_scan_n_to_1 #(.CH_NUM(5), .SEL_W(3), .DATA_W(4), .DWELL_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .din(din5),
    .ch_en(ch_en5), .dwell(dwell5), .dout(dout5), .dout_ch(dout_ch5),
    .dout_valid(valid5), .scan_wrap(wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the 8-channel instance: operating mode, channel on show, cycles shown
  localparam int M_MAN = 0, M_SCAN = 1, M_STALL = 2;
  int   m_state = M_MAN;
  int   m_ch    = 0;
  int   m_age   = 0;
  logic exp_dout  = 1'b0;
  int   exp_ch    = 0;
  logic exp_valid = 1'b0;
  logic exp_wrap  = 1'b0;
  int   exp5_ch    = 0;
  logic [3:0] exp5_dout = '0;

  int exp_seq [10] = '{1, 1, 1, 3, 3, 3, 6, 6, 6, 1};

  function automatic int lowest_en(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_above(input int c, input logic [7:0] m);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_MAN; m_ch = 0; m_age = 0;
    exp_dout = 1'b0; exp_ch = 0; exp_valid = 1'b0; exp_wrap = 1'b0;
  endtask

  // Predict outputs after the coming edge from the inputs currently applied
  task automatic model_step();
    int nx;
    exp_wrap = 1'b0;
    if (!mode) begin
      m_state   = M_MAN;
      exp_ch    = int'(sel);
      exp_valid = 1'b1;
      exp_dout  = din8[exp_ch];
    end else begin
      if (m_state == M_SCAN) begin
        if (m_age >= int'(dwell)) begin
          m_age = 0;
          nx = next_above(m_ch, ch_en);
          if (nx >= 0) m_ch = nx;
          else if (ch_en != 8'h00) begin m_ch = lowest_en(ch_en); exp_wrap = 1'b1; end
          else m_state = M_STALL;
        end else begin
          m_age++;
        end
      end else if (ch_en != 8'h00) begin
        m_state = M_SCAN; m_ch = lowest_en(ch_en); m_age = 0;
      end else begin
        m_state = M_STALL;
      end
      if (m_state == M_SCAN) begin
        exp_ch = m_ch; exp_valid = 1'b1; exp_dout = din8[m_ch];
      end else begin
        exp_valid = 1'b0;
      end
    end
    exp5_ch   = (sel5 > 3'd4) ? 4 : int'(sel5);
    exp5_dout = din5[exp5_ch*4 +: 4];
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".dout"},    32'(dout8),    32'(exp_dout));
    chk({tag, ".ch"},      32'(dout_ch8), 32'(exp_ch));
    chk({tag, ".valid"},   32'(valid8),   32'(exp_valid));
    chk({tag, ".wrap"},    32'(wrap8),    32'(exp_wrap));
    chk({tag, ".d5"},      32'(dout5),    32'(exp5_dout));
    chk({tag, ".ch5"},     32'(dout_ch5), 32'(exp5_ch));
    chk({tag, ".valid5"},  32'(valid5),   32'(1));
  endtask

  initial begin
    logic [7:0] sweep_din;
    rst_n = 1'b1;
    mode = 1'b0; sel = '0; din8 = '0; ch_en = '0; dwell = '0;
    mode5 = 1'b0; sel5 = '0; din5 = '0; ch_en5 = '0; dwell5 = '0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.dout",  32'(dout8),    32'(0));
    chk("rst.ch",    32'(dout_ch8), 32'(0));
    chk("rst.valid", 32'(valid8),   32'(0));
    chk("rst.wrap",  32'(wrap8),    32'(0));
    chk("rst.valid5", 32'(valid5),  32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Manual sweep over a fixed pattern
    sweep_din = 8'b1010_0110;
    din8 = sweep_din;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle("man");
      chk("man.lit", 32'(dout8), 32'(sweep_din[s]));
    end

    // Out-of-range select on the 5-channel instance
    din5 = 20'hABCDE;
    for (int s = 4; s < 8; s++) begin
      sel5 = 3'(s);
      cycle("clamp");
      chk("clamp.lit_d", 32'(dout5), 32'(4'hA));
      chk("clamp.lit_ch", 32'(dout_ch5), 32'(4));
    end

    // Auto-scan over channels 1, 3, 6 with dwell 2
    mode = 1'b1; ch_en = 8'b0100_1010; dwell = 8'd2;
    for (int i = 0; i < 10; i++) begin
      cycle("scan");
      chk("scan.seq", 32'(dout_ch8), 32'(exp_seq[i]));
      chk("scan.wrap_lit", 32'(wrap8), 32'(i == 9));
    end

    // Mask cleared on the first cycle of channel 3
    mode = 1'b0; cycle("back");
    din8 = 8'b0000_1000;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) cycle("pre");
    chk("mask.on3", 32'(dout_ch8), 32'(3));
    ch_en = 8'h00;
    cycle("mask"); cycle("mask");
    chk("mask.still3", 32'(valid8), 32'(1));
    cycle("stall");
    chk("stall.valid", 32'(valid8), 32'(0));
    chk("stall.hold",  32'(dout8),  32'(1));
    din8 = 8'h00;
    cycle("stall");
    chk("stall.hold2", 32'(dout8), 32'(1));
    din8 = 8'b0001_0000;
    ch_en = 8'b0001_0000;
    cycle("resume");
    chk("resume.ch", 32'(dout_ch8), 32'(4));
    chk("resume.v",  32'(valid8),   32'(1));
    mode = 1'b0; sel = 3'd5;
    cycle("to_man");
    chk("to_man.v", 32'(valid8), 32'(1));

    // Dwell shrinks from 7 to 2 while the count is at 5
    mode = 1'b1; ch_en = 8'b0000_0110; dwell = 8'd7;
    for (int i = 0; i < 6; i++) cycle("dw");
    chk("dw.on1", 32'(dout_ch8), 32'(1));
    dwell = 8'd2;
    cycle("dw");
    chk("dw.adv", 32'(dout_ch8), 32'(2));

    // Asynchronous reset in the middle of a scan
    dwell = 8'd0; ch_en = 8'hFF; din8 = 8'hFF;
    cycle("rs"); cycle("rs");
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.dout",  32'(dout8),    32'(0));
    chk("arst.ch",    32'(dout_ch8), 32'(0));
    chk("arst.valid", 32'(valid8),   32'(0));
    chk("arst.wrap",  32'(wrap8),    32'(0));
    mode = 1'b0; sel = 3'd2; din8 = 8'b0000_0100;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post");
    chk("post.lit", 32'(dout8), 32'(1));

    // Randomized traffic against the model
    for (int it = 0; it < 2000; it++) begin
      din8 = 8'($urandom());
      sel  = 3'($urandom());
      din5 = 20'($urandom());
      sel5 = 3'($urandom());
      if ($urandom_range(19, 0) == 0) mode = ~mode;
      if ($urandom_range(14, 0) == 0) begin
        case ($urandom_range(3, 0))
          0:       ch_en = 8'h00;
          1:       ch_en = 8'(1) << $urandom_range(7, 0);
          default: ch_en = 8'($urandom());
        endcase
      end
      if ($urandom_range(24, 0) == 0) dwell = 8'($urandom_range(5, 0));
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
